// File: rtl/unified_mem_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch and data ports.
// D has fixed priority; a pending fetch wins after MAX_WAIT consecutive lost cycles.
module unified_mem_arbiter #(
    parameter int AWIDTH   = 12,
    parameter int MAX_WAIT = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              I_REQ,
    input  logic [AWIDTH-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [31:0]       I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [3:0]        D_BE,
    input  logic [AWIDTH-1:0] D_ADDR,
    input  logic [31:0]       D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [AWIDTH-3:0] MEM_ADDR,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT,
    output logic [31:0]       I_STALL_CNT,
    output logic [31:0]       D_STALL_CNT
);

    // rd_owner | meaning
    // NONE     | no read in flight, MEM_DOUT is not for anyone
    // I        | read granted last cycle belongs to fetch port
    // D        | read granted last cycle belongs to data port
    typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2} owner_t;

    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

    owner_t      rd_owner, rd_owner_nxt;
    logic [7:0]  wait_cnt;
    logic        i_pick, d_pick, d_wr;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic [31:0] i_stall_q, d_stall_q;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{I_ADDR[1:0], D_ADDR[1:0]};

    always_comb begin
        i_pick       = RSTn && I_REQ && (!D_REQ || (wait_cnt == WAIT_MAX));
        d_pick       = RSTn && D_REQ && !i_pick;
        d_wr         = d_pick && D_WE;
        MEM_CSN      = !(i_pick || d_pick);
        MEM_WEN      = !d_wr;
        MEM_BE       = d_wr ? D_BE : 4'b0000;
        MEM_DI       = d_wr ? D_WDATA : 32'h0;
        MEM_ADDR     = '0;
        rd_owner_nxt = OWN_NONE;
        if (d_pick) begin
            MEM_ADDR = D_ADDR[AWIDTH-1:2];
        end else if (i_pick) begin
            MEM_ADDR = I_ADDR[AWIDTH-1:2];
        end
        if (i_pick) begin
            rd_owner_nxt = OWN_I;
        end else if (d_pick && !D_WE) begin
            rd_owner_nxt = OWN_D;
        end
    end

    assign I_GNT       = i_pick;
    assign D_GNT       = d_pick;
    // Gate with RSTn so a read in flight when reset hits is never reported.
    assign I_RVALID    = RSTn && (rd_owner == OWN_I);
    assign D_RVALID    = RSTn && (rd_owner == OWN_D);
    assign I_RDATA     = (rd_owner == OWN_I) ? MEM_DOUT : i_rdata_q;
    assign D_RDATA     = (rd_owner == OWN_D) ? MEM_DOUT : d_rdata_q;
    assign I_STALL_CNT = i_stall_q;
    assign D_STALL_CNT = d_stall_q;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rd_owner  <= OWN_NONE;
            wait_cnt  <= 8'd0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
            i_stall_q <= 32'h0;
            d_stall_q <= 32'h0;
        end else begin
            rd_owner <= rd_owner_nxt;
            if (I_REQ && !i_pick) begin
                if (wait_cnt != WAIT_MAX) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
            if (rd_owner == OWN_I) begin
                i_rdata_q <= MEM_DOUT;
            end
            if (rd_owner == OWN_D) begin
                d_rdata_q <= MEM_DOUT;
            end
            if (I_REQ && !i_pick && (i_stall_q != 32'hFFFF_FFFF)) begin
                i_stall_q <= i_stall_q + 32'd1;
            end
            if (D_REQ && !d_pick && (d_stall_q != 32'hFFFF_FFFF)) begin
                d_stall_q <= d_stall_q + 32'd1;
            end
        end
    end

endmodule
